// File: rtl/ram_block_mover_pkg.sv
// Shared types for the RAM block mover.
// State encoding and command mode constants.
package ram_block_mover_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_block_mover_addr_walker.sv
// Loadable address pointer with a remaining-word counter.
// last_o flags that the current step is the final one.
module addr_walker #(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [AW-1:0] ptr_init_i,
    input  logic [AW-1:0] cnt_init_i,
    output logic [AW-1:0] ptr_o,
    output logic          last_o
);

    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            ptr_d = ptr_init_i;
            cnt_d = cnt_init_i;
        end else if (step_i) begin
            // Pointer wraps modulo 2^AW by plain overflow.
            ptr_d = ptr_q + AW'(1);
            cnt_d = cnt_q - AW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign last_o = (cnt_q == AW'(1));

endmodule

// File: rtl/ram_block_mover.sv
// Single-port RAM block copy / fill engine.
// One command at a time; mem_* decoded from registered state only.
module ram_block_mover
    import ram_block_mover_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SPACE = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_mode,
    input  logic [ADDR_SPACE-1:0] cmd_src,
    input  logic [ADDR_SPACE-1:0] cmd_dst,
    input  logic [ADDR_SPACE-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_fill_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_SPACE-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;

    logic                  load;
    logic                  step_src, step_dst;
    logic [ADDR_SPACE-1:0] src_ptr, dst_ptr;
    logic                  src_last, dst_last;

    addr_walker #(.AW(ADDR_SPACE)) u_src (
        .clock      (clock),
        .reset      (reset),
        .load_i     (load),
        .step_i     (step_src),
        .ptr_init_i (cmd_src),
        .cnt_init_i (cmd_len),
        .ptr_o      (src_ptr),
        .last_o     (src_last)
    );

    addr_walker #(.AW(ADDR_SPACE)) u_dst (
        .clock      (clock),
        .reset      (reset),
        .load_i     (load),
        .step_i     (step_dst),
        .ptr_init_i (cmd_dst),
        .cnt_init_i (cmd_len),
        .ptr_o      (dst_ptr),
        .last_o     (dst_last)
    );

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        fill_d      = fill_q;
        load        = 1'b0;
        step_src    = 1'b0;
        step_dst    = 1'b0;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load   = 1'b1;
                    fill_d = cmd_fill_data;
                    if (cmd_len == '0)
                        state_d = DONE;
                    else if (cmd_mode == MODE_FILL)
                        state_d = FILL;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                mem_address = src_ptr;
                buf_d       = mem_q;
                state_d     = WRITE;
            end
            WRITE: begin
                mem_address = dst_ptr;
                mem_data    = buf_q;
                mem_wren    = 1'b1;
                step_src    = 1'b1;
                step_dst    = 1'b1;
                state_d     = src_last ? DONE : READ;
            end
            FILL: begin
                mem_address = dst_ptr;
                mem_data    = fill_q;
                mem_wren    = 1'b1;
                step_dst    = 1'b1;
                state_d     = dst_last ? DONE : FILL;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ram_block_mover.sv
// Randomised + directed bench for ram_block_mover.
// Expected bus trace per command built from word-level rules.
module tb_ram_block_mover;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [15:0] cmd_src;
    logic [15:0] cmd_dst;
    logic [15:0] cmd_len;
    logic [15:0] cmd_fill_data;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;

    ram_block_mover #(.DATA_WIDTH(16), .ADDR_SPACE(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_src       (cmd_src),
        .cmd_dst       (cmd_dst),
        .cmd_len       (cmd_len),
        .cmd_fill_data (cmd_fill_data),
        .busy          (busy),
        .done          (done),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_wren      (mem_wren),
        .mem_q         (mem_q)
    );

    always #5 clock = ~clock;

    logic [15:0] ram     [65536];
    logic [15:0] ref_mem [65536];

    assign mem_q = ram[mem_address];

    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] = mem_data;
    end

    typedef enum int { E_RD, E_WC, E_WF, E_DN } kind_t;
    typedef struct {
        kind_t       k;
        logic [15:0] a;
        logic [15:0] s;
        logic [15:0] d;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        ce;
    int          tests  = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          pend_v = 1'b0;
    logic [15:0] pend_a;
    logic [15:0] pend_d;
    logic [15:0] xd;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Model memory is updated one edge after the write cycle is checked.
    always @(posedge clock) begin
        cyc++;
        if (reset) pend_v = 1'b0;
        else if (pend_v) begin
            ref_mem[pend_a] = pend_d;
            pend_v = 1'b0;
        end
        #1;
        if (!reset) begin
            if (exp_q.size() == 0) begin
                chk("idle", {cmd_ready, busy, done, mem_wren, mem_address, mem_data},
                    {4'b1000, 32'h0});
            end else begin
                ce = exp_q.pop_front();
                case (ce.k)
                    E_RD: chk("copy_rd", {cmd_ready, busy, done, mem_wren, mem_address},
                              {4'b0100, ce.a});
                    E_WC: begin
                        xd = ref_mem[ce.s];
                        chk("copy_wr", {cmd_ready, busy, done, mem_wren, mem_address, mem_data},
                            {4'b0101, ce.a, xd});
                        pend_v = 1'b1; pend_a = ce.a; pend_d = xd;
                    end
                    E_WF: begin
                        chk("fill_wr", {cmd_ready, busy, done, mem_wren, mem_address, mem_data},
                            {4'b0101, ce.a, ce.d});
                        pend_v = 1'b1; pend_a = ce.a; pend_d = ce.d;
                    end
                    default: chk("done", {cmd_ready, busy, done, mem_wren, mem_address, mem_data},
                                 {4'b0110, 32'h0});
                endcase
            end
        end
    end

    task automatic send(input bit m, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l, input logic [15:0] f, output int acc);
        int w = 0;
        @(negedge clock);
        cmd_mode = m; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_fill_data = f;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        acc = cyc;
        if (!cmd_ready) begin
            chk("accept_timeout", cmd_ready, 1);
            return;
        end
        if (l != 0) begin
            for (int i = 0; i < int'(l); i++) begin
                if (m) exp_q.push_back('{k: E_WF, a: d + 16'(i), s: 16'h0, d: f});
                else begin
                    exp_q.push_back('{k: E_RD, a: s + 16'(i), s: 16'h0, d: 16'h0});
                    exp_q.push_back('{k: E_WC, a: d + 16'(i), s: s + 16'(i), d: 16'h0});
                end
            end
        end
        exp_q.push_back('{k: E_DN, a: 16'h0, s: 16'h0, d: 16'h0});
        @(posedge clock);
    endtask

    task automatic drop_valid();
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge clock);
            w++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int          a1, a2, nmis;
        bit          m;
        logic [15:0] s, d, l;
        cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_src = '0; cmd_dst = '0;
        cmd_len = '0; cmd_fill_data = '0;
        reset = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 16'($urandom);
            ref_mem[i] = ram[i];
        end
        #1;
        chk("reset_state", {cmd_ready, busy, done, mem_wren, mem_address, mem_data},
            {4'b1000, 32'h0});
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Fill with literal readback
        send(1'b1, 16'h0, 16'h0010, 16'd4, 16'hBEEF, a1);
        drop_valid();
        wait_idle();
        for (int i = 0; i < 4; i++) chk("fill_readback", ram[16'h0010 + i], 16'hBEEF);

        // Copy with literal readback
        for (int i = 0; i < 3; i++) begin
            ram[16'h0100 + i]     = 16'(i + 1);
            ref_mem[16'h0100 + i] = 16'(i + 1);
        end
        send(1'b0, 16'h0100, 16'h0200, 16'd3, 16'h0, a1);
        drop_valid();
        wait_idle();
        for (int i = 0; i < 3; i++) chk("copy_readback", ram[16'h0200 + i], i + 1);

        // Zero length
        send(1'b0, 16'h1234, 16'h5678, 16'd0, 16'h0, a1);
        drop_valid();
        wait_idle();

        // Address wrap
        send(1'b1, 16'h0, 16'hFFFE, 16'd3, 16'h00AA, a1);
        drop_valid();
        wait_idle();
        chk("wrap_fffe", ram[16'hFFFE], 16'h00AA);
        chk("wrap_ffff", ram[16'hFFFF], 16'h00AA);
        chk("wrap_0000", ram[16'h0000], 16'h00AA);

        // Back-to-back with cmd_valid held
        send(1'b1, 16'h0, 16'h0400, 16'd2, 16'h1111, a1);
        send(1'b1, 16'h0, 16'h0410, 16'd2, 16'h2222, a2);
        drop_valid();
        wait_idle();
        chk("b2b_gap", a2 - a1, 4);

        // Reset during the third fill write
        for (int i = 0; i < 8; i++) begin
            ram[16'h0300 + i]     = 16'h0;
            ref_mem[16'h0300 + i] = 16'h0;
        end
        send(1'b1, 16'h0, 16'h0300, 16'd8, 16'h1234, a1);
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b1;
        cmd_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_async", {mem_wren, busy, done, cmd_ready}, 4'b0001);
        repeat (2) @(negedge clock);
        chk("rst_word0", ram[16'h0300], 16'h1234);
        chk("rst_word1", ram[16'h0301], 16'h1234);
        for (int i = 2; i < 8; i++) chk("rst_untouched", ram[16'h0300 + i], 16'h0);
        reset = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 1);

        // Randomised commands incl. overlap and wrap
        for (int k = 0; k < 30; k++) begin
            m = 1'($urandom);
            l = 16'($urandom_range(0, 9));
            s = 16'($urandom);
            case ($urandom % 4)
                0: d = 16'($urandom);
                1: d = s + 16'($urandom_range(1, 3));
                2: d = s - 16'($urandom_range(1, 3));
                default: begin
                    s = 16'hFFF8 + 16'($urandom_range(0, 7));
                    d = 16'hFFFA + 16'($urandom_range(0, 5));
                end
            endcase
            send(m, s, d, l, 16'($urandom), a1);
            if ($urandom % 2) begin
                drop_valid();
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
        end
        drop_valid();
        wait_idle();

        nmis = 0;
        for (int i = 0; i < 65536; i++)
            if (ram[i] !== ref_mem[i]) nmis++;
        chk("ram_image", nmis, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Bus initiator that drives the single-port RAM interface: address, write data and write enable out; combinational read data back in.
- Executes one command at a time: either copies a block of words between two RAM regions, or fills a region with a constant.
- Sits between the control-register block (command source) and one single-port RAM instance, for frame-buffer clears and block moves without CPU involvement.

Parameters:
- DATA_WIDTH, 16, width of a RAM word and of cmd_fill_data
- ADDR_SPACE, 16, RAM address width; cmd_src, cmd_dst and cmd_len are this wide

Ports:
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd_mode  input  1  0 = copy, 1 = fill
- cmd_src  input  ADDR_SPACE  copy source start address (ignored in fill mode)
- cmd_dst  input  ADDR_SPACE  destination start address
- cmd_len  input  ADDR_SPACE  word count; 0 is legal
- cmd_fill_data  input  DATA_WIDTH  fill value
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- mem_address  output  ADDR_SPACE  RAM address
- mem_data  output  DATA_WIDTH  RAM write data
- mem_wren  output  1  RAM write enable
- mem_q  input  DATA_WIDTH  RAM read data; combinational from mem_address

Behaviour:
- Interface: one clock, `clock`; reset `reset` is asynchronous and active-high.
- Reset values: state = IDLE, so cmd_ready = 1; busy = 0, done = 0, mem_wren = 0, mem_address = 0, mem_data = 0. Internal counters and buffer are cleared.
- Reset asserted mid-command: mem_wren drops immediately (asynchronously); no further writes occur; the command is lost and no done pulse is produced.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. Command fields are latched on that edge; inputs are don't-care afterwards.
- Timing path: mem_* outputs are decoded from registered state only; there is no combinational path from the cmd_* inputs.
- FSM states: IDLE, READ, WRITE, FILL, DONE.
  - IDLE → DONE if cmd_len == 0 (no RAM access).
  - IDLE → READ if copy mode; IDLE → FILL if fill mode.
  - READ: mem_address = src pointer, mem_wren = 0; mem_q is captured into the buffer register on the edge. READ → WRITE.
  - WRITE: mem_address = dst pointer, mem_data = buffer, mem_wren = 1. On the edge, both pointers increment and the remaining count decrements. Go to READ if remaining ≠ 1, else DONE.
  - FILL: mem_address = dst pointer, mem_data = latched fill value, mem_wren = 1. On the edge, dst increments and remaining decrements. Stay in FILL while remaining ≠ 1, else DONE.
  - DONE: done = 1, cmd_ready = 0 for exactly one cycle; then IDLE.
- Latency, with acceptance on edge T:
  - copy of N words: reads in cycles T+1, T+3, …; writes in cycles T+2, T+4, …; done in cycle T+2N+1.
  - fill of N words: writes in cycles T+1 .. T+N; done in cycle T+N+1.
  - len = 0: done in cycle T+1.
  - Next command is acceptable one cycle after done.
- Pointer arithmetic is modulo 2^ADDR_SPACE: address all-ones wraps to 0 with no error. Full-size length (2^ADDR_SPACE words) cannot be expressed.
- Overlap: copy is strictly forward and word-serial.
  - dst < src: the move is correct.
  - dst inside (src, src+len): source words are overwritten before they are read. This is defined behaviour and is not corrected.
- Outside READ/WRITE/FILL: mem_wren = 0, mem_address = 0, mem_data = 0.

Decomposition:
- Shared package:
  - FSM state encoding constants: IDLE=0, READ=1, WRITE=2, FILL=3, DONE=4, 3 bits.
  - Mode constants: MODE_COPY=0, MODE_FILL=1.
- Sub-module: one natural sub-module, `addr_walker`. It holds the loadable pointer and remaining-count register with increment/decrement and a last flag, and is instantiated twice (src, dst). All else stays in the top-level.

Test Plan:
- Fill: dst=0x0010, len=4, data=0xBEEF → writes at 0x0010..0x0013 in cycles T+1..T+4, each with wren=1; done in T+5; RAM readback is all 0xBEEF.
- Copy: RAM[0x0100..0x0102] = 1, 2, 3; src=0x0100, dst=0x0200, len=3 → wren pattern 0,1,0,1,0,1 over T+1..T+6; done in T+7; RAM[0x0200..0x0202] = 1, 2, 3.
- Zero length: cmd_len=0 → no wren at any time; done in T+1; cmd_ready high again in T+2.
- Wrap: fill dst=0xFFFE, len=3, data=0x00AA → writes at 0xFFFE, 0xFFFF, 0x0000; done in T+4.
- Reset mid-command: start a fill of len=8, assert reset during the 3rd write cycle → wren falls without waiting for an edge; only 2 or 3 words are written; no done pulse; cmd_ready=1 once reset is released.
- Back-to-back: hold cmd_valid high with two fill commands (len=2 each) → the second is accepted exactly one cycle after the first done; cmd_ready=0 throughout the first command.
